// File: rtl/sqrt_unit.sv
// sqrt_unit: unsigned fixed-point square root, digit-by-digit non-restoring, BPC root bits per clock.
// Latency: result valid C+1 cycles after the accepting edge, C = ceil(N/BPC), N = (WIDTH+FBITS)/2.
// Backpressure: result held with out_valid until out_ready; in_ready only in IDLE, or in DONE when out_ready is high.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   radicand handshake; in_rad (WIDTH, FBITS fractional), in_tag (TAG_W sideband)
//   out_valid/out_ready result handshake; out_root (WIDTH), out_rem (WIDTH+1, unrounded remainder),
//                       out_inexact (remainder non-zero), out_tag (tag of the operation)
module sqrt_unit #(
  parameter int WIDTH = 16,
  parameter int FBITS = 0,
  parameter int BPC   = 1,
  parameter int ROUND = 0,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_rad,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_root,
  output logic [WIDTH:0]   out_rem,
  output logic             out_inexact,
  output logic [TAG_W-1:0] out_tag
);

  localparam int N  = (WIDTH + FBITS) / 2;  // root bits
  localparam int RW = 2 * N;                // scaled radicand width
  localparam int AW = N + 2;                // signed partial remainder width
  localparam int LW = $clog2(N + 1);        // remaining-bits counter width

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("sqrt_unit: WIDTH must be in 4..32");
  end
  if (FBITS < 0 || FBITS > WIDTH || ((WIDTH + FBITS) % 2) != 0) begin : g_bad_fbits
    $error("sqrt_unit: FBITS must be 0..WIDTH with WIDTH+FBITS even");
  end
  if (BPC != 1 && BPC != 2) begin : g_bad_bpc
    $error("sqrt_unit: BPC must be 1 or 2");
  end
  if (ROUND != 0 && ROUND != 1) begin : g_bad_round
    $error("sqrt_unit: ROUND must be 0 or 1");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("sqrt_unit: TAG_W must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    rad_q, rad_d;       // radicand, consumed two bits at a time from the top
  logic [AW-1:0]    acc_q, acc_d;       // signed partial remainder
  logic [N-1:0]     root_q, root_d;
  logic [LW-1:0]    left_q, left_d;     // root bits still to resolve
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_root_q, out_root_d;
  logic [WIDTH:0]   out_rem_q, out_rem_d;
  logic             out_inexact_q, out_inexact_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  // One non-restoring step: bring down the next radicand bit pair, then
  // subtract 4q+1 when the remainder is non-negative, otherwise add 4q+3.
  // Wrap-around in the shift is harmless: the true result always fits AW bits.
  function automatic logic [AW-1:0] nr_acc(input logic [AW-1:0] a,
                                           input logic [N-1:0]  q,
                                           input logic [1:0]    b);
    logic [AW-1:0] sh;
    sh = {a[AW-3:0], b};
    if (a[AW-1]) nr_acc = sh + {q, 2'b11};
    else         nr_acc = sh - {q, 2'b01};
  endfunction

  logic             take;
  logic             step_two;
  logic [AW-1:0]    a1, a2;
  logic [N-1:0]     q1, q2;
  logic [LW-1:0]    left_nxt;
  logic [AW-1:0]    rem_fix;
  logic             rnd_up;
  logic [WIDTH-1:0] root_ext;
  logic [WIDTH:0]   root_inc;

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign take     = in_valid && in_ready;

  always_comb begin
    // Datapath for the CALC step(s)
    a1 = nr_acc(acc_q, root_q, rad_q[RW-1:RW-2]);
    q1 = {root_q[N-2:0], ~a1[AW-1]};
    a2 = nr_acc(a1, q1, rad_q[RW-3:RW-4]);
    q2 = {q1[N-2:0], ~a2[AW-1]};
    // Two bits per cycle only while an even count remains, so an odd N
    // spends its first cycle on a single bit.
    step_two = (BPC == 2) && !left_q[0];
    left_nxt = step_two ? (left_q - LW'(2)) : (left_q - LW'(1));

    // Final remainder correction and rounding for FIN
    rem_fix  = acc_q[AW-1] ? (acc_q + {1'b0, root_q, 1'b1}) : acc_q;
    rnd_up   = (ROUND == 1) && (rem_fix > AW'(root_q));
    root_ext = WIDTH'(root_q);
    root_inc = (WIDTH+1)'(root_ext) + (WIDTH+1)'(1);

    state_d       = state_q;
    rad_d         = rad_q;
    acc_d         = acc_q;
    root_d        = root_q;
    left_d        = left_q;
    tag_d         = tag_q;
    out_valid_d   = out_valid_q;
    out_root_d    = out_root_q;
    out_rem_d     = out_rem_q;
    out_inexact_d = out_inexact_q;
    out_tag_d     = out_tag_q;

    case (state_q)
      CALC: begin
        if (step_two) begin
          acc_d  = a2;
          root_d = q2;
          rad_d  = rad_q << 4;
        end else begin
          acc_d  = a1;
          root_d = q1;
          rad_d  = rad_q << 2;
        end
        left_d = left_nxt;
        if (left_nxt == '0) state_d = FIN;
      end
      FIN: begin
        if (!rnd_up)          out_root_d = root_ext;
        else if (root_inc[WIDTH]) out_root_d = '1;
        else                  out_root_d = root_inc[WIDTH-1:0];
        out_rem_d     = (WIDTH+1)'(rem_fix);
        out_inexact_d = |rem_fix;
        out_tag_d     = tag_q;
        out_valid_d   = 1'b1;
        state_d       = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase

    // Acceptance covers both IDLE and the retire-and-accept case in DONE.
    if (take) begin
      rad_d   = RW'(in_rad) << FBITS;
      acc_d   = '0;
      root_d  = '0;
      left_d  = LW'(N);
      tag_d   = in_tag;
      state_d = CALC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rad_q         <= '0;
      acc_q         <= '0;
      root_q        <= '0;
      left_q        <= '0;
      tag_q         <= '0;
      out_valid_q   <= 1'b0;
      out_root_q    <= '0;
      out_rem_q     <= '0;
      out_inexact_q <= 1'b0;
      out_tag_q     <= '0;
    end else begin
      state_q       <= state_d;
      rad_q         <= rad_d;
      acc_q         <= acc_d;
      root_q        <= root_d;
      left_q        <= left_d;
      tag_q         <= tag_d;
      out_valid_q   <= out_valid_d;
      out_root_q    <= out_root_d;
      out_rem_q     <= out_rem_d;
      out_inexact_q <= out_inexact_d;
      out_tag_q     <= out_tag_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_root    = out_root_q;
  assign out_rem     = out_rem_q;
  assign out_inexact = out_inexact_q;
  assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_sqrt_unit.sv
// tb_sqrt_unit: scoreboard bench for sqrt_unit across five parameter sets (all WIDTH=8, TAG_W=4).
// Instances: 0: FBITS0 BPC1, 1: FBITS4 trunc, 2: FBITS4 round, 3: FBITS0 BPC2, 4: FBITS2 BPC2 (odd N).
// Stimulus pushes the expected result when a radicand is accepted; the monitor pops on each handshake.
module tb_sqrt_unit;

  localparam int NI = 5;

  function automatic int fb_of(input int i);
    if (i == 1 || i == 2) fb_of = 4;
    else if (i == 4)      fb_of = 2;
    else                  fb_of = 0;
  endfunction

  function automatic int bpc_of(input int i);
    bpc_of = (i >= 3) ? 2 : 1;
  endfunction

  function automatic int rd_of(input int i);
    rd_of = (i == 2) ? 1 : 0;
  endfunction

  typedef struct {
    int         inst;
    logic [7:0] root;
    logic [8:0] rem;
    logic       inx;
    logic [3:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic       in_valid    [NI];
  logic       in_ready    [NI];
  logic [7:0] in_rad      [NI];
  logic [3:0] in_tag      [NI];
  logic       out_valid   [NI];
  logic       out_ready   [NI];
  logic [7:0] out_root    [NI];
  logic [8:0] out_rem     [NI];
  logic       out_inexact [NI];
  logic [3:0] out_tag     [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sqrt_unit #(
      .WIDTH(8), .FBITS(fb_of(g)), .BPC(bpc_of(g)), .ROUND(rd_of(g)), .TAG_W(4)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_rad     (in_rad[g]),
      .in_tag     (in_tag[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_root   (out_root[g]),
      .out_rem    (out_rem[g]),
      .out_inexact(out_inexact[g]),
      .out_tag    (out_tag[g])
    );
  end

  // Monitor: samples 2 time units before the rising edge.
  always @(negedge clk) begin
    #3;
    for (int i = 0; i < NI; i++) begin
      if (!rst && out_valid[i] && out_ready[i]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result inst %0d: got root=%0d rem=%0d tag=%0d, required no output",
                   i, out_root[i], out_rem[i], out_tag[i]);
        end else begin
          e = sb.pop_front();
          if (e.inst != i || out_root[i] !== e.root || out_rem[i] !== e.rem ||
              out_inexact[i] !== e.inx || out_tag[i] !== e.tag) begin
            errors++;
            $display("FAIL result inst %0d: got root=%0d rem=%0d inexact=%0d tag=%0d, required inst %0d root=%0d rem=%0d inexact=%0d tag=%0d",
                     i, out_root[i], out_rem[i], out_inexact[i], out_tag[i],
                     e.inst, e.root, e.rem, e.inx, e.tag);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Offer a radicand; wait (bounded) for acceptance; queue the expected result.
  task automatic send(input int i, input logic [7:0] rad, input logic [3:0] tag,
                      input logic [7:0] er, input logic [8:0] erem, input logic ei,
                      input bit push, output int acc_cyc);
    int   n;
    exp_t x;
    in_valid[i] = 1'b1;
    in_rad[i]   = rad;
    in_tag[i]   = tag;
    #1;
    n = 0;
    while (!in_ready[i] && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("accept_handshake", int'(in_ready[i]), 1);
    if (in_ready[i] && push) begin
      x.inst = i; x.root = er; x.rem = erem; x.inx = ei; x.tag = tag;
      sb.push_back(x);
    end
    acc_cyc = cyc;
    @(negedge clk);
    #1;
    in_valid[i] = 1'b0;
  endtask

  // Expected result from an integer square-root search.
  task automatic send_m(input int i, input logic [7:0] rad, input logic [3:0] tag);
    int r, rr, rem, root, a;
    rr = int'(rad) << fb_of(i);
    r = 0;
    while ((r + 1) * (r + 1) <= rr) r++;
    rem  = rr - r * r;
    root = r;
    if (rd_of(i) == 1 && rem > r) root = (r + 1 > 255) ? 255 : r + 1;
    send(i, rad, tag, root[7:0], rem[8:0], rem != 0, 1'b1, a);
  endtask

  // Counts edges from the accepting edge until out_valid is seen.
  task automatic wait_valid(input int i, output int n);
    n = 0;
    #1;
    while (!out_valid[i] && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    int n, a1, a2;
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0; in_rad[i] = '0; in_tag[i] = '0; out_ready[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("reset_out_valid",   int'(out_valid[i]), 0);
      check("reset_in_ready",    int'(in_ready[i]), 1);
      check("reset_out_root",    int'(out_root[i]), 0);
      check("reset_out_rem",     int'(out_rem[i]), 0);
      check("reset_out_inexact", int'(out_inexact[i]), 0);
      check("reset_out_tag",     int'(out_tag[i]), 0);
    end
    step();

    // Instance 0: directed values, latency C+1 = 5, throughput C+2 = 6
    send(0, 8'hFF, 4'd3, 8'd15, 9'd30, 1'b1, 1'b1, a1);
    wait_valid(0, n);
    check("latency_bpc1", n, 5);
    send(0, 8'h00, 4'd1, 8'd0, 9'd0, 1'b0, 1'b1, a1);
    send(0, 8'h90, 4'd2, 8'd12, 9'd0, 1'b0, 1'b1, a1);
    send(0, 8'h31, 4'd4, 8'd7, 9'd0, 1'b0, 1'b1, a1);
    send(0, 8'h32, 4'd5, 8'd7, 9'd1, 1'b1, 1'b1, a2);
    check("throughput_interval", a2 - a1, 6);
    drain();

    // Backpressure: result held six cycles, then retire and accept on one edge
    step();
    out_ready[0] = 1'b0;
    send(0, 8'd100, 4'd5, 8'd10, 9'd0, 1'b0, 1'b1, a1);
    wait_valid(0, n);
    check("latency_backpressure", n, 5);
    for (int j = 0; j < 6; j++) begin
      step();
      #1;
      check("hold_out_valid", int'(out_valid[0]), 1);
      check("hold_in_ready",  int'(in_ready[0]), 0);
      check("hold_out_root",  int'(out_root[0]), 10);
      check("hold_out_tag",   int'(out_tag[0]), 5);
    end
    step();
    out_ready[0] = 1'b1;
    send(0, 8'd81, 4'd6, 8'd9, 9'd0, 1'b0, 1'b1, a1);
    #1;
    check("retire_clears_valid", int'(out_valid[0]), 0);
    check("accept_enters_calc",  int'(in_ready[0]), 0);
    #1;
    drain();

    // Reset during CALC: aborted result must never appear; rst beats in_valid
    step();
    send(0, 8'hC8, 4'd7, 8'd0, 9'd0, 1'b0, 1'b0, a1);
    step();
    rst = 1'b1;
    in_valid[0] = 1'b1;
    in_rad[0] = 8'h55;
    step();
    rst = 1'b0;
    in_valid[0] = 1'b0;
    #1;
    check("abort_out_valid", int'(out_valid[0]), 0);
    check("abort_in_ready",  int'(in_ready[0]), 1);
    repeat (8) step();
    check("abort_no_late_valid", int'(out_valid[0]), 0);
    send(0, 8'h90, 4'd8, 8'd12, 9'd0, 1'b0, 1'b1, a1);
    wait_valid(0, n);
    check("latency_after_abort", n, 5);
    drain();

    // Instance 1: FBITS=4 truncating, N=6 so latency 7
    step();
    send(1, 8'h20, 4'd1, 8'd22, 9'd28, 1'b1, 1'b1, a1);
    wait_valid(1, n);
    check("latency_fbits4", n, 7);
    send(1, 8'hFF, 4'd2, 8'd63, 9'd111, 1'b1, 1'b1, a1);
    send(1, 8'h10, 4'd3, 8'd16, 9'd0, 1'b0, 1'b1, a1);
    drain();

    // Instance 2: FBITS=4 rounding; remainder still refers to the truncated root
    step();
    send(2, 8'h20, 4'd1, 8'd23, 9'd28, 1'b1, 1'b1, a1);
    send(2, 8'hFF, 4'd2, 8'd64, 9'd111, 1'b1, 1'b1, a1);
    send(2, 8'h10, 4'd3, 8'd16, 9'd0, 1'b0, 1'b1, a1);
    send(2, 8'h24, 4'd4, 8'd24, 9'd0, 1'b0, 1'b1, a1);
    drain();

    // Instance 3: BPC=2, C=2 so latency 3
    step();
    send(3, 8'hFF, 4'd3, 8'd15, 9'd30, 1'b1, 1'b1, a1);
    wait_valid(3, n);
    check("latency_bpc2", n, 3);
    drain();

    // Instance 4: BPC=2 with N=5, first cycle resolves one bit, C=3 so latency 4
    step();
    send(4, 8'h02, 4'd9, 8'd2, 9'd4, 1'b1, 1'b1, a1);
    wait_valid(4, n);
    check("latency_bpc2_odd", n, 4);
    drain();

    // Exhaustive radicands on both per-clock settings and the odd-N case
    step();
    for (int v = 0; v < 256; v++) send_m(0, 8'(v), 4'(v));
    drain();
    step();
    for (int v = 0; v < 256; v++) send_m(3, 8'(v), 4'(v));
    drain();
    step();
    for (int v = 0; v < 256; v++) send_m(4, 8'(v), 4'(v));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sqrt_unit.md
SQRT_UNIT -- requirements
Module: sqrt_unit

Interface
REQ-001 Parameter WIDTH, default 16, radicand/root width in bits; legal range 4..32.
REQ-002 Parameter FBITS, default 0, fractional bits of radicand and root; (WIDTH+FBITS) SHALL be even and FBITS<=WIDTH, with an elaboration error otherwise.
REQ-003 Parameter BPC, default 1, root bits resolved per clock; legal values 1 or 2.
REQ-004 Parameter ROUND, default 0; 0 = truncate, 1 = round-to-nearest.
REQ-005 Parameter TAG_W, default 4, sideband tag width carried with each operation.
REQ-006 clk  input  1  single clock, all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 in_valid  input  1  radicand offered.
REQ-009 in_ready  output  1  unit accepts radicand this cycle.
REQ-010 in_rad  input  WIDTH  unsigned radicand, FBITS fractional bits.
REQ-011 in_tag  input  TAG_W  sideband, returned unchanged.
REQ-012 out_valid  output  1  result held and valid.
REQ-013 out_ready  input  1  consumer takes result this cycle.
REQ-014 out_root  output  WIDTH  unsigned root, FBITS fractional bits.
REQ-015 out_rem  output  WIDTH+1  unrounded integer remainder.
REQ-016 out_inexact  output  1  remainder non-zero.
REQ-017 out_tag  output  TAG_W  tag of the operation.

Function
REQ-018 Define N=(WIDTH+FBITS)/2 root bits, R=in_rad*2^FBITS, C=ceil(N/BPC) compute cycles.
REQ-019 Truncated root r SHALL satisfy r*r <= R < (r+1)*(r+1); out_rem SHALL equal R-r*r.
REQ-020 With ROUND=1, out_root SHALL be r+1 when out_rem > r, else r, saturating at all-ones; out_rem and out_inexact SHALL still refer to r.
REQ-021 FSM states IDLE, CALC, FIN, DONE; reset state IDLE.
REQ-022 IDLE: in_ready=1; in_valid=1 accepts (transfer edge k), captures in_rad and in_tag, clears root/accumulator, goes to CALC.
REQ-023 CALC: BPC non-restoring root bits per cycle, MSB first; after C cycles goes to FIN.
REQ-024 FIN: applies rounding, loads output registers, goes to DONE.
REQ-025 out_valid SHALL rise on edge k+C+1 and remain high, with all out_* stable, until the edge where out_ready=1.
REQ-026 DONE: in_ready = out_ready; if out_ready and in_valid both high, the result is retired and the new radicand accepted on the same edge (next state CALC); if only out_ready, next state IDLE.
REQ-027 in_ready SHALL be 0 in CALC and FIN; in_valid there is ignored, no input captured.
REQ-028 out_ready while out_valid=0 SHALL have no effect.
REQ-029 When BPC=2 and N is odd, the first CALC cycle resolves one bit only; result identical to BPC=1.
REQ-030 Throughput: one result per C+2 cycles under continuous in_valid/out_ready.
REQ-031 Internal accumulator SHALL be N+2 bits wide; no intermediate overflow for any legal parameter set.

Reset
REQ-032 On rst=1 at an edge: state IDLE, out_valid=0, in_ready=1 next cycle, out_root/out_rem/out_tag=0, out_inexact=0.
REQ-033 rst SHALL abort any CALC/FIN/DONE operation; the aborted result SHALL never appear on outputs.
REQ-034 rst has priority over in_valid and out_ready in the same cycle.

Verification
REQ-035 WIDTH=8,FBITS=0,BPC=1: in_rad=0xFF, tag=3 -> out_root=15, out_rem=30, inexact=1, tag=3, out_valid at edge k+5.
REQ-036 Same config: in_rad=0 -> root=0, rem=0, inexact=0; in_rad=0x90 -> root=12, rem=0, inexact=0.
REQ-037 WIDTH=8,FBITS=4: in_rad=0x20 (2.0) -> root=22 (1.375), rem=28; with ROUND=1 root=23, rem=28.
REQ-038 BPC=2 vs BPC=1 on exhaustive 8-bit radicands -> identical outputs; BPC=2 latency C=2 (out_valid at k+3).
REQ-039 Backpressure: out_ready low 6 cycles after out_valid -> outputs stable, in_ready=0; then out_ready=1 with in_valid=1 -> retire and accept on the same edge.
REQ-040 rst pulse during CALC -> out_valid=0 and in_ready=1 the next cycle; following operation yields correct result with no stale data.
